// File: rtl/mips_bp_pkg.sv
// Shared types, counter constants and PC field helpers
// for the branch target buffer (branch_predictor).
package mips_bp_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_TAG_W  = 8;
    localparam int DEF_CTR_W  = 2;

    // Layout of one table entry in the default configuration.
    typedef struct packed {
        logic                  valid;
        logic [DEF_TAG_W-1:0]  tag;
        logic [DEF_ADDR_W-1:0] target;
        logic [DEF_CTR_W-1:0]  ctr;
    } bp_entry_t;

    // Counter value that saturates upward (all ones).
    function automatic int unsigned CTR_MAX(
        input int unsigned ctrW
    );
        return (32'd1 << ctrW) - 32'd1;
    endfunction

    // Weakly taken: MSB set, every other bit clear.
    function automatic int unsigned CTR_WEAK_TAKEN(
        input int unsigned ctrW
    );
        return 32'd1 << (ctrW - 1);
    endfunction

    // Table index: pc[idxW+1:2].
    function automatic int unsigned bp_index(
        input logic [63:0] pc,
        input int unsigned idxW
    );
        logic [63:0] mask;
        mask = (64'd1 << idxW) - 64'd1;
        return 32'((pc >> 2) & mask);
    endfunction

    // Tag: the tagW bits directly above the index.
    function automatic int unsigned bp_tag(
        input logic [63:0] pc,
        input int unsigned idxW,
        input int unsigned tagW
    );
        logic [63:0] mask;
        mask = (64'd1 << tagW) - 64'd1;
        return 32'((pc >> (idxW + 2)) & mask);
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state function of a CTR_W-bit saturating counter.
// Ports: taken (direction), cur (present value), nxt (next value).
module bp_sat_counter
    import mips_bp_pkg::*;
#(
    parameter int CTR_W = 2
) (
    input  logic             taken,
    input  logic [CTR_W-1:0] cur,
    output logic [CTR_W-1:0] nxt
);

    localparam logic [CTR_W-1:0] MAXV =
        CTR_W'(CTR_MAX(CTR_W));

    always_comb begin
        nxt = cur;
        if (taken) begin
            if (cur != MAXV) begin
                nxt = cur + CTR_W'(1);
            end
        end else if (cur != '0) begin
            nxt = cur - CTR_W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer: combinational lookup for IF,
// clocked update from EX. Optional statistics via the macro
// BRANCH_PREDICTOR_STATS_EN (upd_mispredict, stat_updates,
// stat_mispredicts). Ports: clk, rst (sync, active-high),
// lookup_pc -> pred_hit/pred_taken/pred_target,
// upd_valid/upd_pc/upd_taken/upd_target.
module branch_predictor
    import mips_bp_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    input  logic              upd_mispredict,
    output logic [31:0]       stat_updates,
    output logic [31:0]       stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] WEAK =
        CTR_W'(CTR_WEAK_TAKEN(CTR_W));

    logic              validQ  [ENTRIES];
    logic [TAG_W-1:0]  tagQ    [ENTRIES];
    logic [ADDR_W-1:0] targetQ [ENTRIES];
    logic [CTR_W-1:0]  ctrQ    [ENTRIES];

    logic [IDX_W-1:0] lookIdx;
    logic [TAG_W-1:0] lookTag;
    logic             lookHit;

    logic [IDX_W-1:0] updIdx;
    logic [TAG_W-1:0] updTag;
    logic             updHit;
    logic [CTR_W-1:0] ctrNxt;

    assign lookIdx = IDX_W'(bp_index(64'(lookup_pc), IDX_W));
    assign lookTag = TAG_W'(bp_tag(64'(lookup_pc), IDX_W, TAG_W));
    assign updIdx  = IDX_W'(bp_index(64'(upd_pc), IDX_W));
    assign updTag  = TAG_W'(bp_tag(64'(upd_pc), IDX_W, TAG_W));

    // Lookup reads the current table only; an update in the
    // same cycle becomes visible one cycle later.
    always_comb begin
        lookHit     = validQ[lookIdx] &&
                      (tagQ[lookIdx] == lookTag);
        pred_hit    = lookHit;
        pred_taken  = lookHit && ctrQ[lookIdx][CTR_W-1];
        pred_target = lookHit ? targetQ[lookIdx] : '0;
    end

    assign updHit = validQ[updIdx] &&
                    (tagQ[updIdx] == updTag);

    bp_sat_counter #(
        .CTR_W (CTR_W)
    ) uCtr (
        .taken (upd_taken),
        .cur   (ctrQ[updIdx]),
        .nxt   (ctrNxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                validQ[i]  <= 1'b0;
                tagQ[i]    <= '0;
                targetQ[i] <= '0;
                ctrQ[i]    <= '0;
            end
        end else if (upd_valid) begin
            if (updHit) begin
                ctrQ[updIdx] <= ctrNxt;
                if (upd_taken) begin
                    targetQ[updIdx] <= upd_target;
                end
            end else if (upd_taken) begin
                // Allocate, or evict an alias at this index.
                validQ[updIdx]  <= 1'b1;
                tagQ[updIdx]    <= updTag;
                targetQ[updIdx] <= upd_target;
                ctrQ[updIdx]    <= WEAK;
            end
        end
    end

`ifdef BRANCH_PREDICTOR_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_updates     <= '0;
            stat_mispredicts <= '0;
        end else if (upd_valid) begin
            if (stat_updates != 32'hFFFF_FFFF) begin
                stat_updates <= stat_updates + 32'd1;
            end
            if (upd_mispredict &&
                stat_mispredicts != 32'hFFFF_FFFF) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios
// followed by random traffic against a table model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lookup_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
`ifdef BRANCH_PREDICTOR_STATS_EN
    logic        upd_mispredict;
    logic [31:0] stat_updates;
    logic [31:0] stat_mispredicts;
`endif

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk         (clk),
        .rst         (rst),
        .lookup_pc   (lookup_pc),
        .pred_hit    (pred_hit),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target)
`ifdef BRANCH_PREDICTOR_STATS_EN
        ,
        .upd_mispredict   (upd_mispredict),
        .stat_updates     (stat_updates),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    typedef struct {
        string       name;
        bit          hit;
        bit          taken;
        logic [31:0] target;
        int unsigned su;
        int unsigned sm;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    // Model: a 64-slot table, 8-bit tags, 2-bit counters.
    bit          mValid  [64];
    int unsigned mTag    [64];
    logic [31:0] mTarget [64];
    int          mCtr    [64];
    int unsigned mSu;
    int unsigned mSm;

    function automatic int idxOf(logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic int unsigned tagOf(logic [31:0] pc);
        return (pc / 256) % 256;
    endfunction

    function automatic void modelClear();
        for (int i = 0; i < 64; i++) begin
            mValid[i]  = 0;
            mTag[i]    = 0;
            mTarget[i] = 0;
            mCtr[i]    = 0;
        end
        mSu = 0;
        mSm = 0;
    endfunction

    task automatic check(string nm, logic [31:0] act,
                         logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h",
                     nm, act, req);
        end
    endtask

    // Monitor: lookup is combinational, so every cycle presents
    // a result; compare mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            check({e.name, ".hit"}, 32'(pred_hit), 32'(e.hit));
            check({e.name, ".taken"}, 32'(pred_taken),
                  32'(e.taken));
            check({e.name, ".target"}, pred_target, e.target);
`ifdef BRANCH_PREDICTOR_STATS_EN
            check({e.name, ".su"}, stat_updates, e.su);
            check({e.name, ".sm"}, stat_mispredicts, e.sm);
`endif
        end
    end

    // One cycle: drive, predict the lookup from the model as it
    // stands, then after the edge apply the update to the model.
    task automatic step(string nm, logic [31:0] lpc,
                        bit uv, logic [31:0] upc, bit ut,
                        logic [31:0] utg, bit r, bit mp);
        exp_t e;
        int   i;
        bit   hit;
        rst        = r;
        lookup_pc  = lpc;
        upd_valid  = uv;
        upd_pc     = upc;
        upd_taken  = ut;
        upd_target = utg;
`ifdef BRANCH_PREDICTOR_STATS_EN
        upd_mispredict = mp;
`endif
        i = idxOf(lpc);
        hit = mValid[i] && mTag[i] == tagOf(lpc);
        e.name   = nm;
        e.hit    = hit;
        e.taken  = hit && mCtr[i] >= 2;
        e.target = hit ? mTarget[i] : 32'd0;
        e.su     = mSu;
        e.sm     = mSm;
        sbq.push_back(e);
        @(posedge clk);
        if (r) begin
            modelClear();
        end else if (uv) begin
            mSu++;
            if (mp) mSm++;
            i = idxOf(upc);
            hit = mValid[i] && mTag[i] == tagOf(upc);
            if (hit) begin
                if (ut) begin
                    mCtr[i] = (mCtr[i] < 3) ? mCtr[i] + 1 : 3;
                    mTarget[i] = utg;
                end else begin
                    mCtr[i] = (mCtr[i] > 0) ? mCtr[i] - 1 : 0;
                end
            end else if (ut) begin
                mValid[i]  = 1;
                mTag[i]    = tagOf(upc);
                mTarget[i] = utg;
                mCtr[i]    = 2;
            end
        end
        #1;
    endtask

    task automatic look(string nm, logic [31:0] lpc);
        step(nm, lpc, 0, 0, 0, 0, 0, 0);
    endtask

    // Small address pool so hits and aliases are frequent;
    // high bits and pc[1:0] vary to show they are ignored.
    function automatic logic [31:0] rndPc();
        logic [31:0] pc;
        pc = ($urandom & 32'hFFFF_0000) |
             ($urandom_range(0, 3) << 8) |
             ($urandom_range(0, 7) << 2) |
             $urandom_range(0, 3);
        return pc;
    endfunction

    initial begin
        modelClear();
        rst        = 1'b1;
        lookup_pc  = 32'h100;
        upd_valid  = 1'b0;
        upd_pc     = '0;
        upd_taken  = 1'b0;
        upd_target = '0;
`ifdef BRANCH_PREDICTOR_STATS_EN
        upd_mispredict = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;

        look("s1_reset", 32'h100);

        step("s2_upd", 32'h100, 1, 32'h100, 1, 32'h200, 0, 0);
        look("s2_hit", 32'h100);

        for (int k = 0; k < 3; k++)
            step("s3_nt", 32'h100, 1, 32'h100, 0, 32'h0, 0, 0);
        look("s3_nt_done", 32'h100);
        for (int k = 0; k < 4; k++)
            step("s3_t", 32'h100, 1, 32'h100, 1, 32'h200, 0, 0);
        look("s3_sat", 32'h100);

        look("s4_alias", 32'h4100);
        step("s4_nt", 32'h100, 1, 32'h4100, 0, 32'h300, 0, 0);
        look("s4_keep", 32'h100);
        step("s4_t", 32'h4100, 1, 32'h4100, 1, 32'h300, 0, 0);
        look("s4_new", 32'h4100);
        look("s4_old", 32'h100);

        step("s5_fill", 32'h100, 1, 32'h100, 1, 32'h200, 0, 0);
        step("s5_same", 32'h100, 1, 32'h100, 1, 32'h500, 0, 0);
        look("s5_next", 32'h100);

        step("s6_rst", 32'h180, 1, 32'h180, 1, 32'h700, 1, 0);
        look("s6_a", 32'h180);
        look("s6_b", 32'h100);
        step("s6_u1", 32'h180, 1, 32'h180, 1, 32'h10, 0, 0);
        step("s6_u2", 32'h180, 1, 32'h180, 0, 32'h10, 0, 1);
        step("s6_u3", 32'h180, 1, 32'h104, 0, 32'h10, 0, 0);
        look("s6_stats", 32'h180);

        for (int k = 0; k < 600; k++) begin
            step("rnd", rndPc(), 1'($urandom_range(0, 1)),
                 rndPc(), 1'($urandom_range(0, 1)),
                 $urandom, ($urandom_range(0, 79) == 0),
                 1'($urandom_range(0, 1)));
        end
        look("final", 32'h100);

        for (int k = 0; k < 10 && sbq.size() > 0; k++)
            @(posedge clk);
        check("drain", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
